csa_word_sequencer: RTL and testbench

Multi-cycle word adder front end. Accepts a WIDTH-bit operand pair and carry-in over a valid/ready handshake, then walks the operands one 4-bit nibble per clock through a 4-bit carry-select nibble adder, chaining the carry between nibbles. Returns the full sum, carry-out and signed-overflow flag over a second valid/ready handshake. Sits directly upstream of the 4-bit carry-select adder and owns the operand slicing and carry chaining that the adder itself lacks.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_nibble_add.sv | 38 +++
 rtl/csa_word_sequencer.sv | 128 ++++++++++++
 tb/tb_csa_word_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the nibble-serial word adder.
// State enum, nibble width and nibble-count helper.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/csa_nibble_add.sv
// Combinational 4-bit carry-select adder: two ripple chains + muxes.
// Ports: a, b, cin in; sum, c3 (carry into bit 3), cout out.
module csa_nibble_add
  import csa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c3,
  output logic                cout
);

  logic [NIBBLE_W:0]   k0;
  logic [NIBBLE_W:0]   k1;
  logic [NIBBLE_W-1:0] s0;
  logic [NIBBLE_W-1:0] s1;

  always_comb begin
    k0    = '0;
    k1    = '0;
    s0    = '0;
    s1    = '0;
    k0[0] = 1'b0;
    k1[0] = 1'b1;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s0[i]   = a[i] ^ b[i] ^ k0[i];
      k0[i+1] = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ k1[i];
      k1[i+1] = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign c3   = cin ? k1[NIBBLE_W-1] : k0[NIBBLE_W-1];
  assign cout = cin ? k1[NIBBLE_W] : k0[NIBBLE_W];

endmodule

// File: rtl/csa_word_sequencer.sv
// Nibble-serial word adder around one carry-select nibble adder.
// in_* valid/ready operand port; out_* valid/ready result port.
module csa_word_sequencer
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N     = nib_count(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [NIBBLE_W-1:0] na;
  logic [NIBBLE_W-1:0] nb;
  logic [NIBBLE_W-1:0] ns;
  logic                nc3;
  logic                ncout;
  logic                last;

  always_comb begin
    na = '0;
    nb = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        na = a_q[i*NIBBLE_W +: NIBBLE_W];
        nb = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign last = (idx_q == IDX_W'(N - 1));

  csa_nibble_add u_nib (
    .a    (na),
    .b    (nb),
    .cin  (carry_q),
    .sum  (ns),
    .c3   (nc3),
    .cout (ncout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
              sum_q[i*NIBBLE_W +: NIBBLE_W] <= ns;
            end
          end
          carry_q <= ncout;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            cout_q      <= ncout;
            ovf_q       <= nc3 ^ ncout;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Randomized self-checking bench for csa_word_sequencer (WIDTH=16).
// Reference model uses plain 17-bit arithmetic and sign rules.
module tb_csa_word_sequencer;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  csa_word_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold);
    logic [W+1:0] e;
    logic [W-1:0] s0;
    int lat;
    e = model(a, b, cin);
    wait_ready();
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    chk("sum", {16'd0, out_sum}, {16'd0, e[W-1:0]});
    chk("cout", {31'd0, out_cout}, {31'd0, e[W]});
    chk("ovf", {31'd0, out_ovf}, {31'd0, e[W+1]});
    s0 = out_sum;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum_stable", {16'd0, out_sum}, {16'd0, s0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("taken_valid", {31'd0, out_valid}, 32'd0);
    chk("taken_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W+1:0] exq[$];
    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    logic         qc[3];
    int           acc[$];
    int           sent;
    int           got;
    logic         adv;
    logic [W+1:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    run_op(16'h5A5A, 16'hA5A5, 1'b1, 3);

    // reset during RUN
    wait_ready();
    in_a     = 16'hABCD;
    in_b     = 16'h1111;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_sum", {16'd0, out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    // back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 3; k++) begin
      qa[k] = W'($urandom);
      qb[k] = W'($urandom);
      qc[k] = 1'($urandom);
    end
    wait_ready();
    sent      = 0;
    got       = 0;
    adv       = 1'b0;
    out_ready = 1'b1;
    in_a      = qa[0];
    in_b      = qb[0];
    in_cin    = qc[0];
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (adv) begin
        adv = 1'b0;
        if (sent < 3) begin
          in_a   = qa[sent];
          in_b   = qb[sent];
          in_cin = qc[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exq.size() == 0) begin
          chk("b2b_spurious", 32'd1, 32'd0);
        end else begin
          e = exq.pop_front();
          chk("b2b_sum", {16'd0, out_sum}, {16'd0, e[W-1:0]});
          chk("b2b_flags", {30'd0, out_ovf, out_cout},
              {30'd0, e[W+1], e[W]});
        end
        got++;
      end
      if (in_ready && in_valid) begin
        exq.push_back(model(in_a, in_b, in_cin));
        acc.push_back(cyc);
        sent++;
        adv = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepted", sent, 3);
    chk("b2b_results", got, 3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 6);
      chk("b2b_gap2", acc[2] - acc[1], 6);
    end else begin
      chk("b2b_acc_count", acc.size(), 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
